// File: rtl/prbs_gen_checker.sv
// Selectable PRBS7/9/15/23/31 generator with a self-synchronising checker.
// Both sides process DATA_W bits per cycle, MSB first in time.
module prbs_gen_checker #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           mode,
  input  logic [30:0]          seed,
  input  logic                 load,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [DATA_W-1:0]    tx_data,
  input  logic                 rx_valid,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(DATA_W + 1);
  localparam int SW = ERR_CNT_W + MW;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  generate
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
      $error("prbs_gen_checker: DATA_W must be 1..32");
    end
    if (LOCK_CNT < 1 || LOCK_CNT * DATA_W < 31) begin : g_bad_lock
      $error("prbs_gen_checker: LOCK_CNT*DATA_W must be >= 31");
    end
  endgenerate

  typedef enum logic {HUNT, LOCK} chk_st_e;

  function automatic logic [4:0] poly_len(input logic [2:0] m);
    case (m)
      3'd1:    return 5'd9;
      3'd2:    return 5'd15;
      3'd3:    return 5'd23;
      3'd4:    return 5'd31;
      default: return 5'd7;
    endcase
  endfunction

  function automatic logic [4:0] poly_tap(input logic [2:0] m);
    case (m)
      3'd1:    return 5'd5;
      3'd2:    return 5'd14;
      3'd3:    return 5'd18;
      3'd4:    return 5'd28;
      default: return 5'd6;
    endcase
  endfunction

  function automatic logic [30:0] len_mask(input logic [4:0] l);
    return 31'h7FFF_FFFF >> (5'd31 - l);
  endfunction

  // State
  logic [2:0]           mode_q, mode_d;
  logic [30:0]          gen_q, gen_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  chk_st_e              st_q, st_d;
  logic [30:0]          chk_q, chk_d;
  logic [CW-1:0]        clean_q, clean_d;
  logic [CW-1:0]        bad_q, bad_d;
  logic                 locked_q, locked_d;
  logic                 err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [2:0]        mode_eff;
  logic              reload;
  logic [4:0]        len, tap;
  logic [30:0]       mask, seed_m;
  logic [30:0]       g_s, c_s, h_s;
  logic              g_bit, g_fb, c_bit;
  logic [DATA_W-1:0] g_word, exp_word, diff;
  logic [MW-1:0]     mism;
  logic              add_err;
  logic [ERR_CNT_W-1:0] err_base;
  logic [SW-1:0]     err_sum;

  assign mode_eff = (mode > 3'd4) ? 3'd0 : mode;
  assign reload   = load | (mode_eff != mode_q);
  assign len      = poly_len(mode_q);
  assign tap      = poly_tap(mode_q);
  assign mask     = len_mask(len);
  assign seed_m   = seed & len_mask(poly_len(mode_eff));

  // Generator emits s[L-1]; the checker instead holds the last L received
  // bits, so its next predicted bit is the feedback term itself.
  always_comb begin
    g_s      = gen_q;
    c_s      = chk_q;
    h_s      = chk_q;
    g_word   = '0;
    exp_word = '0;
    g_bit    = 1'b0;
    g_fb     = 1'b0;
    c_bit    = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      g_bit     = g_s[len - 5'd1];
      g_fb      = g_bit ^ g_s[tap - 5'd1];
      g_word[i] = g_bit;
      g_s       = ((g_s << 1) | 31'(g_fb)) & mask;
      c_bit       = c_s[len - 5'd1] ^ c_s[tap - 5'd1];
      exp_word[i] = c_bit;
      c_s         = ((c_s << 1) | 31'(c_bit)) & mask;
      h_s         = ((h_s << 1) | 31'(rx_data[i])) & mask;
    end
  end

  assign diff = exp_word ^ rx_data;

  always_comb begin
    mism = '0;
    for (int i = 0; i < DATA_W; i++) mism = mism + MW'(diff[i]);
  end

  always_comb begin
    mode_d     = mode_eff;
    gen_d      = gen_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (reload) begin
      gen_d      = (seed_m == '0) ? 31'd1 : seed_m;
      tx_valid_d = 1'b0;
    end else if (!tx_valid_q || tx_ready) begin
      tx_data_d  = g_word;
      gen_d      = g_s;
      tx_valid_d = 1'b1;
    end
  end

  always_comb begin
    st_d       = st_q;
    chk_d      = chk_q;
    clean_d    = clean_q;
    bad_d      = bad_q;
    locked_d   = locked_q;
    err_flag_d = 1'b0;
    add_err    = 1'b0;
    if (reload) begin
      st_d     = HUNT;
      clean_d  = '0;
      bad_d    = '0;
      locked_d = 1'b0;
      if (rx_valid) chk_d = h_s;
    end else if (rx_valid) begin
      case (st_q)
        HUNT: begin
          chk_d = h_s;
          if (mism != '0) begin
            clean_d = '0;
          end else if (clean_q == CW'(LOCK_CNT - 1)) begin
            st_d     = LOCK;
            locked_d = 1'b1;
            clean_d  = '0;
            bad_d    = '0;
          end else begin
            clean_d = clean_q + 1'b1;
          end
        end
        LOCK: begin
          chk_d = c_s;
          if (mism == '0) begin
            bad_d = '0;
          end else begin
            err_flag_d = 1'b1;
            add_err    = 1'b1;
            if (bad_q == CW'(LOCK_CNT - 1)) begin
              st_d     = HUNT;
              locked_d = 1'b0;
              clean_d  = '0;
              bad_d    = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
        default: st_d = HUNT;
      endcase
    end
  end

  // Clear takes effect before this cycle's errors are added.
  always_comb begin
    err_base    = clr_err ? '0 : err_count_q;
    err_sum     = SW'(err_base) + SW'(mism);
    err_count_d = err_base;
    if (add_err)
      err_count_d = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= 3'd0;
      gen_q       <= 31'h7F;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      st_q        <= HUNT;
      chk_q       <= '0;
      clean_q     <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      mode_q      <= mode_d;
      gen_q       <= gen_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      st_q        <= st_d;
      chk_q       <= chk_d;
      clean_q     <= clean_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign locked    = locked_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_gen_checker.sv
// Directed bench: loopback tx->rx with hand-computed PRBS words, error
// injection, backpressure, seed-zero load, saturation and async reset.
module tb_prbs_gen_checker;
  localparam int DW = 8;
  localparam int EW = 4;
  localparam int LC = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    mode;
  logic [30:0]   seed;
  logic          load, tx_ready, clr_err;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          locked, err_flag;
  logic [EW-1:0] err_count;
  logic [DW-1:0] flip;

  logic [DW-1:0] w [0:255];
  int n_chk = 0;
  int n_err = 0;
  int nflag;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  assign rx_valid = tx_valid & tx_ready;
  assign rx_data  = tx_data ^ flip;

  prbs_gen_checker #(.DATA_W(DW), .ERR_CNT_W(EW), .LOCK_CNT(LC)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .seed(seed), .load(load),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .clr_err(clr_err),
    .locked(locked), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; mode = 3'd0; seed = '0; load = 1'b0;
    tx_ready = 1'b1; clr_err = 1'b0; flip = '0;
    repeat (2) tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;

    // PRBS7 from all-ones: FE, 04, period 127 bits
    nflag = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i < 129) w[i] = tx_data;
      if (i == 0) chk("p7_first_valid", 32'(tx_valid), 32'd1);
      if (i == 12) chk("p7_lock", 32'(locked), 32'd1);
      if (err_flag) nflag++;
    end
    chk("p7_w0", 32'(w[0]), 32'hFE);
    chk("p7_w1", 32'(w[1]), 32'h04);
    chk("p7_w127", 32'(w[127]), 32'hFE);
    chk("p7_w128", 32'(w[128]), 32'h04);
    chk("p7_flags", 32'(nflag), 32'd0);
    chk("p7_errcnt", 32'(err_count), 32'd0);

    // 1-bit then 3-bit error while locked
    flip = 8'h01; tick(); flip = 8'h00;
    chk("inj1_flag", 32'(err_flag), 32'd1);
    chk("inj1_cnt", 32'(err_count), 32'd1);
    tick();
    chk("inj_gap_flag", 32'(err_flag), 32'd0);
    flip = 8'h07; tick(); flip = 8'h00;
    chk("inj3_flag", 32'(err_flag), 32'd1);
    chk("inj_total", 32'(err_count), 32'd4);
    tick();
    chk("inj_locked", 32'(locked), 32'd1);
    chk("inj_after_flag", 32'(err_flag), 32'd0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_alone", 32'(err_count), 32'd0);

    // Modes 1..4 from all-ones seed via mode change
    for (int m = 1; m <= 4; m++) begin
      mode = 3'(m); seed = 31'h7FFF_FFFF;
      tick();
      chk("mchg_valid_low", 32'(tx_valid), 32'd0);
      chk("mchg_unlock", 32'(locked), 32'd0);
      nflag = 0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (i < 8) w[i] = tx_data;
        if (i == 12) chk("mode_lock", 32'(locked), 32'd1);
        if (err_flag) nflag++;
      end
      chk("mode_w0", 32'(w[0]), 32'hFF);
      case (m)
        1: begin chk("p9_w1", 32'(w[1]), 32'h83); chk("p9_w2", 32'(w[2]), 32'hDF); end
        2: begin chk("p15_w1", 32'(w[1]), 32'hFE); chk("p15_w3", 32'(w[3]), 32'h04); end
        3: begin chk("p23_w2", 32'(w[2]), 32'hFE); chk("p23_w5", 32'(w[5]), 32'h7C); end
        default: begin chk("p31_w3", 32'(w[3]), 32'hFE); chk("p31_w7", 32'(w[7]), 32'h1C); end
      endcase
      chk("mode_flags", 32'(nflag), 32'd0);
      chk("mode_errcnt", 32'(err_count), 32'd0);
    end

    // Random backpressure (PRBS31)
    nflag = 0;
    for (int i = 0; i < 600; i++) begin
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      tick();
      if (prev_stall) begin
        chk("bp_valid_hold", 32'(tx_valid), 32'd1);
        chk("bp_data_hold", 32'(tx_data), 32'(prev_data));
      end
      if (err_flag) nflag++;
      tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    chk("bp_flags", 32'(nflag), 32'd0);
    chk("bp_locked", 32'(locked), 32'd1);
    chk("bp_errcnt", 32'(err_count), 32'd0);

    // Zero seed on PRBS15 loads state 1
    mode = 3'd2; seed = '0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("ld_valid_low", 32'(tx_valid), 32'd0);
    chk("ld_hunt", 32'(locked), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      w[i] = tx_data;
    end
    chk("ld0_w0", 32'(w[0]), 32'h00);
    chk("ld0_w1", 32'(w[1]), 32'h02);
    chk("ld_relock", 32'(locked), 32'd1);

    // Inverted stream: lock held for LC-1 bad words, lost on the LC-th
    flip = 8'hFF;
    repeat (LC - 1) tick();
    chk("inv_still_locked", 32'(locked), 32'd1);
    tick();
    flip = 8'h00;
    chk("inv_unlock", 32'(locked), 32'd0);
    chk("sat_errcnt", 32'(err_count), 32'd15);

    repeat (12) tick();
    chk("relock2", 32'(locked), 32'd1);
    flip = 8'h81; clr_err = 1'b1;
    tick();
    flip = 8'h00; clr_err = 1'b0;
    chk("clr_plus_err", 32'(err_count), 32'd2);
    chk("clr_plus_flag", 32'(err_flag), 32'd1);

    // Async reset mid-stream
    reset_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_err_flag", 32'(err_flag), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    mode = 3'd0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(tx_valid), 32'd1);
    chk("post_rst_w0", 32'(tx_data), 32'hFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/prbs_gen_checker.md
Name: prbs_gen_checker

Overview:
Parametrised multi-polynomial PRBS generator and self-synchronising checker sharing one clock domain. The generator emits DATA_W bits per transfer over a valid/ready stream. The checker consumes a received stream, acquires lock, and counts bit errors. It is the link-test block for the serial datapaths, generalising the fixed single-polynomial 7-bit PRNG to selectable PRBS7/9/15/23/31, parallel width, loadable seeding, backpressure and error checking.

Parameters:
DATA_W, 8, bits per transfer (1..32); tx_data[DATA_W-1] is the first bit in time.
ERR_CNT_W, 16, width of the saturating error counter.
LOCK_CNT, 4, consecutive clean words needed to lock, and consecutive errored words that drop lock; LOCK_CNT*DATA_W must be >= 31 (elaboration check).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
mode  in  3  polynomial select: 0 PRBS7 x^7+x^6+1; 1 PRBS9 x^9+x^5+1; 2 PRBS15 x^15+x^14+1; 3 PRBS23 x^23+x^18+1; 4 PRBS31 x^31+x^28+1; 5-7 treated as 0.
seed  in  31  generator seed; low L bits are used (L = polynomial degree).
load  in  1  sync pulse: load seed into the generator and force the checker to HUNT.
tx_ready  in  1  downstream accepts tx_data.
tx_valid  out  1  tx_data valid.
tx_data  out  DATA_W  generated word.
rx_valid  in  1  rx_data valid.
rx_data  in  DATA_W  received word to check; MSB is first in time.
clr_err  in  1  sync pulse: clear err_count.
locked  out  1  checker is in LOCK.
err_flag  out  1  one-cycle pulse: the checked word had ≥1 bit error while in LOCK.
err_count  out  ERR_CNT_W  saturating count of bit errors seen in LOCK.

Behaviour:
- LFSR step, Fibonacci, on active width L: out = s[L-1]; fb = s[L-1]^s[T-1], where T is the non-degree tap (6, 5, 14, 18, 28); s <= {s[L-2:0], fb}. Bits above L-1 are held at 0.
- One word = DATA_W steps computed combinationally in one cycle.
- Reset (async, reset_n=0):
  - generator state = all-ones in L bits;
  - tx_valid=0, tx_data=0;
  - checker state=0 in HUNT, locked=0, err_flag=0, err_count=0.
- Generator:
  - First clock after reset release: tx_data = first word from the state, tx_valid=1, and the state advances DATA_W steps.
  - tx_valid then stays 1.
  - On tx_valid&&tx_ready, load the next word and advance. Otherwise tx_data and the state hold (no data loss under backpressure).
- load=1:
  - state <= seed[L-1:0], or 1 if that value is zero (all-zero lockup prevented);
  - tx_valid <= 0 for that cycle, with normal refill on the next cycle;
  - load overrides a concurrent handshake; the word presented in the load cycle is discarded.
- A change of mode is treated exactly like load with the current seed. Mode is registered, and the change is detected on a registered-vs-input mismatch.
- Checker, active only on rx_valid=1; exp = word predicted from the checker state; mism = popcount(exp^rx_data).
  - HUNT: state <= the state shifted with the received bits (self-sync, state = last L received bits). A clean word (mism=0) increments the clean counter and a dirty word zeroes it. Reaching LOCK_CNT moves to LOCK and sets locked=1 on the next cycle. No counting in HUNT.
  - LOCK: state <= own prediction (free-running, not reseeded from rx). If mism>0: err_flag pulses for 1 cycle, err_count += mism (saturates at all-ones) and the bad counter increments. A clean word zeroes the bad counter. When the bad counter reaches LOCK_CNT, go to HUNT, locked=0 and the clean counter=0.
  - rx_valid=0: all checker state holds; err_flag=0.
- clr_err together with an error in the same cycle: err_count <= mism (clear, then add). clr_err alone → 0.
- load or mode change forces HUNT and clears the clean and bad counters; err_count is untouched.
- Reset asserted mid-operation: all of the above reset values apply immediately (asynchronously).

Test Plan:
- PRBS7, DATA_W=8, tx_ready=1 after reset → tx_data 0xFE then 0x04. Sequence period = 127 bits; the word after 127 words equals the first word.
- Loopback tx→rx, mode 0..4 each → locked=1 within LOCK_CNT+ceil(31/DATA_W) words; err_count stays 0 for 1000 words.
- Once locked, flip 1 bit in one word, then 3 bits in another → err_flag pulses twice; err_count=4; locked remains 1.
- tx_ready toggled pseudo-randomly (loopback on handshake) → no errors; tx_data stable while tx_valid&&!tx_ready.
- load with seed=0, mode 2 → state loads 1; tx_valid low one cycle; checker drops to HUNT then relocks. Then invert rx_data for LOCK_CNT words → locked=0.
- ERR_CNT_W=4, continuous errors → err_count saturates at 15. clr_err concurrent with a 2-bit error → err_count=2. reset_n pulsed mid-stream → all outputs at reset values immediately.
